// File: rtl/sdram_bus_width_adapter.sv
// rtl/sdram_bus_width_adapter.sv - 32-bit host word to 16-bit SDRAM controller bus adapter
//
// Splits each host word access into two halfword bus commands (low half first)
// and reassembles read returns into one 32-bit response. One host transaction
// is in flight at a time. Write halves with no enabled byte lanes are skipped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   host_valid/host_ready    host request handshake (ready depends on state only)
//   host_write, host_addr    request type and byte address (bits [1:0] ignored)
//   host_wdata/byteenable    write data and byte lanes
//   host_rvalid/host_rdata   one-cycle read completion pulse and assembled word
//   bus_read/bus_write       controller command strobes, held until bus_ready
//   bus_addr/wdata/be        halfword command address, data and lanes
//   bus_burst/burst_len      tied off (single accesses only)
//   bus_rvalid/bus_rdata     controller read return strobe and halfword
module sdram_bus_width_adapter #(
  parameter int AW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  input  logic          host_write,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic [3:0]    host_byteenable,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic          bus_read,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic          bus_burst,
  output logic [2:0]    bus_burst_len,
  output logic [15:0]   bus_wdata,
  output logic [1:0]    bus_byteenable,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [15:0]   bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RWAIT} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] base_q;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [1:0]    rcnt_q;
  logic [15:0]   lo_q;

  logic accept;
  logic rd_ret;
  logic rd_last;
  logic rd_both;

  assign host_ready    = (state == S_IDLE);
  assign accept        = host_valid & host_ready;
  assign bus_burst     = 1'b0;
  assign bus_burst_len = 3'd0;

  // Returns only count while a read is outstanding; anything beyond the
  // second halfword, in IDLE, or during a write is dropped.
  assign rd_ret  = (state != S_IDLE) & ~wr_q & bus_rvalid & (rcnt_q != 2'd2);
  assign rd_last = rd_ret & (rcnt_q == 2'd1);
  // Both halves may be back before the high command is accepted; the one
  // arriving in the same cycle counts too, otherwise RWAIT would never exit.
  assign rd_both = (rcnt_q == 2'd2) | rd_last;

  always_comb begin
    state_nx       = state;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_addr       = '0;
    bus_wdata      = '0;
    bus_byteenable = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!host_write || (host_byteenable[1:0] != 2'b00)) state_nx = S_LO;
          else if (host_byteenable[3:2] != 2'b00)            state_nx = S_HI;
        end
      end
      S_LO: begin
        bus_read       = ~wr_q;
        bus_write      = wr_q;
        bus_addr       = base_q;
        bus_wdata      = wdata_q[15:0];
        bus_byteenable = wr_q ? be_q[1:0] : 2'b11;
        if (bus_ready) begin
          if (!wr_q || (be_q[3:2] != 2'b00)) state_nx = S_HI;
          else                               state_nx = S_IDLE;
        end
      end
      S_HI: begin
        bus_read       = ~wr_q;
        bus_write      = wr_q;
        bus_addr       = base_q + AW'(2);
        bus_wdata      = wdata_q[31:16];
        bus_byteenable = wr_q ? be_q[3:2] : 2'b11;
        if (bus_ready) begin
          if (wr_q || rd_both) state_nx = S_IDLE;
          else                 state_nx = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (rd_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      base_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rcnt_q      <= '0;
      lo_q        <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nx;
      host_rvalid <= rd_last;
      if (accept) begin
        base_q  <= {host_addr[AW-1:2], 2'b00};
        wr_q    <= host_write;
        wdata_q <= host_wdata;
        be_q    <= host_byteenable;
        rcnt_q  <= 2'd0;
      end else if (rd_ret) begin
        rcnt_q <= rcnt_q + 2'd1;
        if (rcnt_q == 2'd0) lo_q <= bus_rdata;
        if (rd_last)        host_rdata <= {bus_rdata, lo_q};
      end
    end
  end

endmodule

// File: tb/tb_sdram_bus_width_adapter.sv
// tb/tb_sdram_bus_width_adapter.sv - self-checking bench for sdram_bus_width_adapter
module tb_sdram_bus_width_adapter;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_valid;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [3:0]    host_byteenable;
  logic          host_ready;
  logic          host_rvalid;
  logic [31:0]   host_rdata;
  logic          bus_read;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic          bus_burst;
  logic [2:0]    bus_burst_len;
  logic [15:0]   bus_wdata;
  logic [1:0]    bus_byteenable;
  logic          bus_ready;
  logic          bus_rvalid;
  logic [15:0]   bus_rdata;

  sdram_bus_width_adapter #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_write(host_write), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_byteenable(host_byteenable),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_burst(bus_burst), .bus_burst_len(bus_burst_len),
    .bus_wdata(bus_wdata), .bus_byteenable(bus_byteenable),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
  } cmd_t;

  int nchk = 0;
  int nerr = 0;
  int ncmd = 0;
  int nrv  = 0;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_rd[$];
  logic [15:0] rq[$];
  logic [7:0]  hmem[int];
  logic [7:0]  smem[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input logic cond);
    nchk++;
    assert (cond === 1'b1) else begin
      nerr++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  function automatic logic [7:0] dflt(input int a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] hb(input int a);
    return hmem.exists(a) ? hmem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] sb(input int a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  // One clock: host-level bookkeeping for what is taken at the coming edge,
  // then the edge, then output sampling 1 time unit later.
  task automatic cyc();
    cmd_t obs, e;
    int   base;
    if (bus_read | bus_write) chk("rd_wr_exclusive", {bus_read, bus_write}, 2'b10 ^ {1'b0, bus_write} ^ {bus_write, 1'b0});
    if ((bus_read | bus_write) && bus_ready) begin
      ncmd++;
      obs = '{rd: bus_read, wr: bus_write, addr: bus_addr,
              wdata: (bus_write ? bus_wdata : 16'h0), be: bus_byteenable};
      chk_true("cmd_expected", exp_cmd.size() != 0);
      if (exp_cmd.size() != 0) begin
        e = exp_cmd.pop_front();
        chk("bus_cmd", 64'(obs), 64'(e));
      end
      if (bus_write) begin
        for (int j = 0; j < 2; j++)
          if (bus_byteenable[j]) smem[int'(bus_addr) + j] = bus_wdata[8*j +: 8];
      end else begin
        rq.push_back({sb(int'(bus_addr) + 1), sb(int'(bus_addr))});
      end
    end
    if (bus_rvalid && rq.size() != 0) void'(rq.pop_front());
    if (host_valid && host_ready) begin
      base = int'({host_addr[AW-1:2], 2'b00});
      if (!host_write) begin
        exp_cmd.push_back('{1'b1, 1'b0, AW'(base), 16'h0, 2'b11});
        exp_cmd.push_back('{1'b1, 1'b0, AW'(base + 2), 16'h0, 2'b11});
        exp_rd.push_back({hb(base + 3), hb(base + 2), hb(base + 1), hb(base)});
      end else begin
        if (host_byteenable[1:0] != 0)
          exp_cmd.push_back('{1'b0, 1'b1, AW'(base), host_wdata[15:0], host_byteenable[1:0]});
        if (host_byteenable[3:2] != 0)
          exp_cmd.push_back('{1'b0, 1'b1, AW'(base + 2), host_wdata[31:16], host_byteenable[3:2]});
        for (int i = 0; i < 4; i++)
          if (host_byteenable[i]) hmem[base + i] = host_wdata[8*i +: 8];
      end
    end
    @(posedge clk);
    #1;
    if (host_rvalid) begin
      nrv++;
      chk_true("rvalid_expected", exp_rd.size() != 0);
      if (exp_rd.size() != 0) chk("host_rdata", host_rdata, exp_rd.pop_front());
    end
  endtask

  task automatic drive_random();
    bus_ready = ($urandom_range(0, 99) < 60);
    if (rq.size() != 0 && $urandom_range(0, 99) < 50) begin
      bus_rvalid = 1'b1;
      bus_rdata  = rq[0];
    end else begin
      bus_rvalid = 1'b0;
      bus_rdata  = 16'($urandom);
    end
  endtask

  task automatic drive_fixed(input logic rdy, input logic rv);
    bus_ready  = rdy;
    bus_rvalid = rv && (rq.size() != 0);
    bus_rdata  = (rq.size() != 0) ? rq[0] : 16'hFFFF;
  endtask

  task automatic wait_idle(input logic rnd);
    int n;
    n = 0;
    while (!(host_ready && exp_cmd.size() == 0 && exp_rd.size() == 0) && n < 300) begin
      if (rnd) drive_random(); else drive_fixed(1'b1, 1'b1);
      cyc();
      n++;
    end
    chk_true("idle_timeout", n < 300);
    bus_rvalid = 1'b0;
  endtask

  task automatic host_req(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    host_valid      = 1'b1;
    host_write      = w;
    host_addr       = a;
    host_wdata      = d;
    host_byteenable = be;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0;
    rst = 1'b1;
    host_valid = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    host_byteenable = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_ready", host_ready, 1);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_bus_cmd", {bus_read, bus_write}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_byteenable, 0);
    chk("tie_burst", {bus_burst, bus_burst_len}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write, bus always ready.
    host_req(1'b1, 26'h100, 32'hDEADBEEF, 4'hF);
    drive_fixed(1'b1, 1'b0);
    cyc();
    host_valid = 1'b0;
    chk("wr_lo", {bus_write, bus_addr, bus_wdata, bus_byteenable}, {1'b1, 26'h100, 16'hBEEF, 2'b11});
    chk("wr_lo_ready", host_ready, 0);
    cyc();
    chk("wr_hi", {bus_write, bus_addr, bus_wdata, bus_byteenable}, {1'b1, 26'h102, 16'hDEAD, 2'b11});
    cyc();
    chk("wr_done_ready", host_ready, 1);
    chk("wr_done_idle", {bus_read, bus_write}, 0);

    // Put 0x12345678 at 0x200, then read it back through unaligned 0x203.
    host_req(1'b1, 26'h200, 32'h12345678, 4'hF);
    cyc();
    host_valid = 1'b0;
    wait_idle(1'b0);
    host_req(1'b0, 26'h203, 32'h0, 4'h0);
    drive_fixed(1'b1, 1'b0);
    r0 = nrv;
    cyc();
    host_valid = 1'b0;
    chk("rd_lo", {bus_read, bus_addr, bus_byteenable}, {1'b1, 26'h200, 2'b11});
    cyc();
    chk("rd_hi", {bus_read, bus_addr}, {1'b1, 26'h202});
    drive_fixed(1'b1, 1'b1);
    cyc();
    drive_fixed(1'b1, 1'b1);
    cyc();
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 32'h12345678);
    chk("rd_ready_with_rvalid", host_ready, 1);
    drive_fixed(1'b1, 1'b0);
    cyc();
    chk("rd_rvalid_pulse", host_rvalid, 0);
    chk("rd_rdata_hold", host_rdata, 32'h12345678);
    chk("rd_single_pulse", nrv - r0, 1);

    // Upper half only, then nothing at all.
    c0 = ncmd;
    host_req(1'b1, 26'h300, 32'hA1B2C3D4, 4'b1100);
    cyc();
    host_valid = 1'b0;
    chk("be_hi_addr", {bus_write, bus_addr, bus_wdata, bus_byteenable}, {1'b1, 26'h302, 16'hA1B2, 2'b11});
    wait_idle(1'b0);
    chk("be_hi_one_cmd", ncmd - c0, 1);
    c0 = ncmd;
    host_req(1'b1, 26'h304, 32'h55555555, 4'b0000);
    cyc();
    host_valid = 1'b0;
    chk("be_none_ready", host_ready, 1);
    chk("be_none_no_cmd", {bus_read, bus_write}, 0);
    cyc();
    chk("be_none_cmds", ncmd - c0, 0);

    // LO stalled for 5 cycles.
    host_req(1'b1, 26'h108, 32'hCAFEF00D, 4'hF);
    drive_fixed(1'b0, 1'b0);
    cyc();
    host_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_lo", {bus_write, bus_addr, bus_wdata, bus_byteenable}, {1'b1, 26'h108, 16'hF00D, 2'b11});
      cyc();
    end
    chk("stall_lo_last", {bus_write, bus_addr}, {1'b1, 26'h108});
    drive_fixed(1'b1, 1'b0);
    cyc();
    chk("stall_then_hi", {bus_write, bus_addr, bus_wdata}, {1'b1, 26'h10A, 16'hCAFE});
    wait_idle(1'b0);

    // First return lands while HI is still waiting for bus_ready.
    r0 = nrv;
    host_req(1'b0, 26'h100, 32'h0, 4'h0);
    drive_fixed(1'b1, 1'b0);
    cyc();
    host_valid = 1'b0;
    cyc();
    drive_fixed(1'b0, 1'b1);
    cyc();
    chk("hi_ret_still_hi", {bus_read, bus_addr}, {1'b1, 26'h102});
    drive_fixed(1'b0, 1'b0);
    cyc();
    wait_idle(1'b0);
    chk("hi_ret_single", nrv - r0, 1);
    chk("hi_ret_data", host_rdata, 32'hDEADBEEF);

    // Reset with one halfword returned, then a stray return.
    host_req(1'b0, 26'h200, 32'h0, 4'h0);
    drive_fixed(1'b1, 1'b0);
    cyc();
    host_valid = 1'b0;
    cyc();
    drive_fixed(1'b1, 1'b1);
    cyc();
    bus_rvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", {bus_read, bus_write, bus_addr, bus_byteenable}, 0);
    chk("mid_rst_out", {host_ready, host_rvalid, host_rdata}, {1'b1, 1'b0, 32'h0});
    exp_cmd.delete(); exp_rd.delete(); rq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 16'h9999;
    r0 = nrv;
    cyc();
    bus_rvalid = 1'b0;
    cyc();
    chk("stray_ignored", {nrv - r0, 32'(host_rdata)}, 0);
    chk("stray_ready", host_ready, 1);
    host_req(1'b0, 26'h200, 32'h0, 4'h0);
    drive_fixed(1'b1, 1'b0);
    cyc();
    host_valid = 1'b0;
    wait_idle(1'b0);
    chk("post_rst_read", host_rdata, 32'h12345678);

    // Random traffic against the host-level memory model.
    for (int t = 0; t < 200; t++) begin
      host_req($urandom_range(0, 1) == 1, AW'($urandom_range(0, 127)), $urandom,
               4'($urandom_range(0, 15)));
      drive_random();
      cyc();
      host_valid = 1'b0;
      wait_idle(1'b1);
    end
    chk("final_queues", {32'(exp_cmd.size()), 32'(exp_rd.size())}, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sdram_bus_width_adapter.md
# sdram_bus_width_adapter

Upstream stage for the SDRAM controller: converts a 32-bit single-word host request interface into the controller's 16-bit system bus. Each host word becomes two sequential halfword accesses (low half first). Read returns are reassembled into one 32-bit response. One host transaction is in flight at a time; halfwords with all byte lanes disabled are skipped on writes.

## Interface
Parameters:
- AW, 26, byte-address width shared with the controller bus
- Data widths are fixed: host 32 bits, controller 16 bits

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- host_valid  in  1  request present
- host_write  in  1  1 = write, 0 = read; sampled with host_valid
- host_addr  in  AW  byte address; bits [1:0] ignored (word aligned)
- host_wdata  in  32  write data
- host_byteenable  in  4  byte lanes for writes; ignored for reads
- host_ready  out  1  adapter can accept; request taken when host_valid & host_ready
- host_rvalid  out  1  one-cycle pulse, read word complete
- host_rdata  out  32  assembled read data
- bus_read, bus_write  out  1 each  controller command strobes
- bus_addr  out  AW  halfword byte address
- bus_burst  out  1  tied 0
- bus_burst_len  out  3  tied 0
- bus_wdata  out  16  halfword write data
- bus_byteenable  out  2  halfword lanes
- bus_ready  in  1  controller accepts the current command this cycle
- bus_rvalid  in  1  controller read-data strobe
- bus_rdata  in  16  controller read data

## Operation
- Capture on accept: addr base {host_addr[AW-1:2],2'b00}, write flag, wdata, byteenable.
- States: IDLE, LO, HI, RWAIT.
- IDLE: host_ready=1. On accept:
  - read → LO.
  - write with be[1:0]≠0 → LO.
  - write with be[1:0]=0 and be[3:2]≠0 → HI.
  - write with be=0 → stays IDLE. No bus activity. Transaction complete.
- LO: drive command at addr base, wdata[15:0], bus_byteenable=be[1:0] (reads: 2'b11). On bus_ready:
  - read → HI.
  - write with be[3:2]≠0 → HI.
  - otherwise → IDLE.
- HI: drive command at base+2, wdata[31:16], bus_byteenable=be[3:2] (reads: 2'b11). On bus_ready: write → IDLE; read → RWAIT, or IDLE if both halves already returned.
- RWAIT: leave for IDLE in the cycle the second halfword is received.
- Read reassembly: a 2-bit return counter is cleared on accept and incremented on each bus_rvalid while a read is active (LO/HI/RWAIT).
  - 1st return → rdata[15:0]; 2nd → rdata[31:16].
  - Returns may arrive while still in HI.
- host_rvalid pulses for 1 cycle, registered, the cycle after the 2nd bus_rvalid.
- host_rdata holds its value until the next read completes.
- bus_rvalid in IDLE, or during a write, is ignored.
- Commands are held stable (addr/data/be) until bus_ready. bus_read/bus_write are never both high.

## Timing
- Reset values: state IDLE, host_ready=1, host_rvalid=0, host_rdata=0, bus_read=bus_write=0, bus_addr=0, bus_wdata=0, bus_byteenable=0.
- Reset mid-transaction: all commands drop immediately. Late bus_rvalid after reset is ignored.
- Accept in cycle T → first bus command visible in T+1. With bus_ready always 1, a full write occupies T+1 and T+2, and host_ready is high again in T+3.
- Read latency: host_rvalid = cycle after the 2nd bus_rvalid. host_ready rises in that same cycle.
- host_ready is combinational from state only; it does not depend on host_valid.

## Test plan
- Write 0xDEADBEEF, addr 0x100, be=4'hF, bus_ready=1 → bus_write at 0x100/0xBEEF/be 2'b11, then 0x102/0xDEAD/be 2'b11 on consecutive cycles; host_ready back high 3 cycles after accept.
- Read addr 0x203 → commands at 0x200 then 0x202. Returns 0x5678 then 0x1234 → host_rvalid pulse once with host_rdata=0x12345678.
- Write be=4'b1100 → single bus_write at base+2 only. be=4'b0000 → no bus command, host_ready stays 1.
- bus_ready held low 5 cycles during LO → bus_addr/bus_wdata/bus_byteenable stable throughout; HI issued only after acceptance.
- First bus_rvalid arriving while still in HI (bus_ready low for HI) → data still assembled correctly; single host_rvalid.
- Assert rst while in RWAIT with one halfword returned, then deliver a stray bus_rvalid → outputs at reset values, no host_rvalid. A subsequent read completes with correct data.
